// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-file write-back control slice.
// Round-robin arbitration is selected by defining REG_WB_RR_EN at build time.
package reg_ctrl_pkg;

    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;
    localparam int N_REQ_DEF = 3;
    localparam int REG_COUNT = 32;

    typedef logic [1:0] req_idx_t;

    localparam logic [AW_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_wb_pick.sv
// Combinational requester picker: first valid at or after the start pointer,
// wrapping modulo N. With the pointer tied to 0 it is a fixed lowest-index priority.
module reg_wb_pick
    import reg_ctrl_pkg::*;
#(
    parameter int N = N_REQ_DEF
) (
    input  logic [N-1:0] i_valid,
    input  req_idx_t     i_ptr,
    output logic [N-1:0] o_grant,
    output req_idx_t     o_idx
);

    always_comb begin
        logic found;
        int   j;
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!found && i_valid[j]) begin
                found      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = req_idx_t'(j);
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter driving the register file write port from a registered stage,
// plus the pending-write scoreboard. REG_WB_RR_EN enables round-robin arbitration.
module reg_wb_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*AW-1:0]   req_addr,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [DW-1:0]         wr_data,
    output logic [1:0]            wr_src,
    input  logic                  sb_set_valid,
    input  logic [AW-1:0]         sb_set_addr,
    output logic [REG_COUNT-1:0]  sb_busy
);

    logic [N_REQ-1:0]     w_grant;
    req_idx_t             w_idx;
    req_idx_t             w_ptr;
    logic                 w_xfer;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_data;
    logic [REG_COUNT-1:0] w_sb_clr;
    logic [REG_COUNT-1:0] w_sb_set;
    logic [REG_COUNT-1:0] w_sb_next;

    logic                 r_wr_en;
    logic [AW-1:0]        r_wr_addr;
    logic [DW-1:0]        r_wr_data;
    req_idx_t             r_wr_src;
    logic [REG_COUNT-1:0] r_sb;

    reg_wb_pick #(.N(N_REQ)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;
    assign w_addr    = req_addr[int'(w_idx)*AW +: AW];
    assign w_data    = req_data[int'(w_idx)*DW +: DW];

`ifdef REG_WB_RR_EN
    req_idx_t r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 2'd1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // Register 0 still completes its handshake but never reaches the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
        end else if (w_xfer) begin
            r_wr_en   <= (w_addr != AW'(ZERO_REG));
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
            r_wr_src  <= w_idx;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Clear is applied before set so an issue and a write-back to the same
    // register on one edge leave it pending.
    always_comb begin
        w_sb_clr = '0;
        w_sb_set = '0;
        if (w_xfer)
            w_sb_clr[w_addr] = 1'b1;
        if (sb_set_valid)
            w_sb_set[sb_set_addr] = 1'b1;
        w_sb_next = (r_sb & ~w_sb_clr) | w_sb_set;
        w_sb_next[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sb <= '0;
        else
            r_sb <= w_sb_next;
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign wr_src  = r_wr_src;
    assign sb_busy = r_sb;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus a randomized run
// against a queue-free behavioural model of arbitration and scoreboard rules.
module tb_reg_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [1:0]      wr_src;
    logic            sb_set_valid;
    logic [AW-1:0]   sb_set_addr;
    logic [31:0]     sb_busy;

    logic [AW-1:0]   t_addr [N];
    logic [DW-1:0]   t_data [N];

    int vectors = 0;
    int errors  = 0;

    assign req_addr = {t_addr[2], t_addr[1], t_addr[0]};
    assign req_data = {t_data[2], t_data[1], t_data[0]};

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_src       (wr_src),
        .sb_set_valid (sb_set_valid),
        .sb_set_addr  (sb_set_addr),
        .sb_busy      (sb_busy)
    );

    // Winner = first valid requester scanning upward from the start pointer.
    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic clear_inputs();
        req_valid    = '0;
        sb_set_valid = 1'b0;
        sb_set_addr  = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = AW'(i + 1);
            t_data[i] = 32'h1000 + i;
        end
        sb_set_valid = 1'b0;
        sb_set_addr  = '0;
        #1;
        vectors++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_ready got=%b exp=001", req_ready); end
        vectors++; if (wr_en !== 1'b0)       begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        vectors++; if (wr_addr !== '0 || wr_data !== '0 || wr_src !== '0)
            begin errors++; $display("FAIL reset_wr_port got=%h/%h/%h exp=0/0/0", wr_addr, wr_data, wr_src); end
        vectors++; if (sb_busy !== '0)       begin errors++; $display("FAIL reset_sb got=%h exp=0", sb_busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (wr_en !== 1'b1 || wr_src !== 2'd0 || wr_addr !== 5'd1)
            begin errors++; $display("FAIL reset_first_write got en=%b src=%0d addr=%0d exp en=1 src=0 addr=1", wr_en, wr_src, wr_addr); end
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 3'b010;
        t_addr[1] = 5'd5;
        t_data[1] = 32'hDEADBEEF;
        #1;
        vectors++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        vectors++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF || wr_src !== 2'd1)
            begin errors++; $display("FAIL single_write got en=%b addr=%0d data=%h src=%0d exp 1/5/deadbeef/1", wr_en, wr_addr, wr_data, wr_src); end
        @(posedge clk); #1;
        vectors++; if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF)
            begin errors++; $display("FAIL single_hold got en=%b addr=%0d data=%h exp 0/5/deadbeef", wr_en, wr_addr, wr_data); end
    endtask

    task automatic test_contention();
        int exp_src;
        do_reset();
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            t_addr[i] = AW'(i + 1);
            t_data[i] = 32'hC0 + i;
        end
        for (int c = 0; c < 6; c++) begin
`ifdef REG_WB_RR_EN
            exp_src = c % N;
`else
            exp_src = 0;
`endif
            #1;
            vectors++; if (req_ready !== 3'(1 << exp_src))
                begin errors++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, req_ready, 3'(1 << exp_src)); end
            @(posedge clk); #1;
            vectors++; if (wr_en !== 1'b1 || wr_src !== 2'(exp_src))
                begin errors++; $display("FAIL contention_src c=%0d got en=%b src=%0d exp en=1 src=%0d", c, wr_en, wr_src, exp_src); end
        end
        clear_inputs();
    endtask

    task automatic test_scoreboard();
        do_reset();
        sb_set_valid = 1'b1; sb_set_addr = 5'd7;
        @(posedge clk); #1;
        sb_set_valid = 1'b0;
        vectors++; if (sb_busy !== 32'h80) begin errors++; $display("FAIL sb_set got=%h exp=00000080", sb_busy); end
        req_valid = 3'b001; t_addr[0] = 5'd7; t_data[0] = 32'h77;
        @(posedge clk); #1;
        req_valid = '0;
        vectors++; if (wr_en !== 1'b1 || sb_busy !== 32'h0)
            begin errors++; $display("FAIL sb_clear got en=%b sb=%h exp en=1 sb=0", wr_en, sb_busy); end
        sb_set_valid = 1'b1; sb_set_addr = 5'd7;
        @(posedge clk); #1;
        req_valid = 3'b001;
        @(posedge clk); #1;
        sb_set_valid = 1'b0; req_valid = '0;
        vectors++; if (wr_en !== 1'b1 || sb_busy !== 32'h80)
            begin errors++; $display("FAIL sb_set_wins got en=%b sb=%h exp en=1 sb=00000080", wr_en, sb_busy); end
    endtask

    task automatic test_reg0();
        do_reset();
        sb_set_valid = 1'b1; sb_set_addr = 5'd0;
        @(posedge clk); #1;
        sb_set_valid = 1'b0;
        vectors++; if (sb_busy !== 32'h0) begin errors++; $display("FAIL reg0_set got=%h exp=0", sb_busy); end
        req_valid = 3'b100; t_addr[2] = 5'd0; t_data[2] = 32'h55;
        #1;
        vectors++; if (req_ready !== 3'b100) begin errors++; $display("FAIL reg0_ready got=%b exp=100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        vectors++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reg0_wr_en got=%b exp=0", wr_en); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb_set_valid = 1'b1; sb_set_addr = 5'd9;
        req_valid = 3'b010; t_addr[1] = 5'd9; t_data[1] = 32'h99;
        @(posedge clk); #1;
        sb_set_valid = 1'b0; req_valid = '0;
        vectors++; if (wr_en !== 1'b1 || sb_busy !== 32'h200)
            begin errors++; $display("FAIL midrst_pre got en=%b sb=%h exp en=1 sb=00000200", wr_en, sb_busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (wr_en !== 1'b0 || sb_busy !== 32'h0)
            begin errors++; $display("FAIL midrst got en=%b sb=%h exp en=0 sb=0", wr_en, sb_busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int          m_ptr;
        logic [31:0] m_busy;
        logic        e_en;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        int          e_src;
        int          g;
        do_reset();
        m_ptr = 0; m_busy = '0; e_en = 1'b0; e_addr = '0; e_data = '0; e_src = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 2) != 0)) begin
                    req_valid[i] = 1'b1;
                    t_addr[i] = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    t_data[i] = $urandom;
                end
            end
            sb_set_valid = ($urandom_range(0, 1) == 1);
            sb_set_addr  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) sb_set_addr = t_addr[$urandom_range(0, N - 1)];
            #1;
`ifdef REG_WB_RR_EN
            g = pick(req_valid, m_ptr);
`else
            g = pick(req_valid, 0);
`endif
            vectors++; if (req_ready !== ((g < 0) ? 3'b000 : 3'(1 << g)))
                begin errors++; $display("FAIL rand_ready c=%0d got=%b exp_idx=%0d", c, req_ready, g); end
            if (g >= 0) begin
                e_en = (t_addr[g] != 5'd0);
                e_addr = t_addr[g];
                e_data = t_data[g];
                e_src = g;
                m_busy[t_addr[g]] = 1'b0;
                m_ptr = (g + 1) % N;
            end else begin
                e_en = 1'b0;
            end
            if (sb_set_valid) m_busy[sb_set_addr] = 1'b1;
            m_busy[0] = 1'b0;
            @(posedge clk); #1;
            if (g >= 0) req_valid[g] = 1'b0;
            vectors++; if (wr_en !== e_en || wr_addr !== e_addr || wr_data !== e_data || wr_src !== 2'(e_src))
                begin errors++; $display("FAIL rand_port c=%0d got %b/%0d/%h/%0d exp %b/%0d/%h/%0d", c, wr_en, wr_addr, wr_data, wr_src, e_en, e_addr, e_data, e_src); end
            vectors++; if (sb_busy !== m_busy)
                begin errors++; $display("FAIL rand_sb c=%0d got=%h exp=%h", c, sb_busy, m_busy); end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_scoreboard();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32 register file. Shares the register file's single write port between up to N_REQ write-back sources (ALU, load unit, multi-cycle mul/div) using a valid/ready handshake, and drives the port from a registered stage. Tracks which architectural registers have an issued but not yet written result, so the hazard unit can stall dependent reads. Sits between the execute/memory write-back sources and the register file write port.

## Interface
- N_REQ, 3: number of write-back requesters (2..4).
- AW, 5: register address width.
- DW, 32: data width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  requester i has a write pending.
- req_ready  out  N_REQ  one-hot or zero; grant to requester i this cycle.
- req_addr  in  N_REQ*AW  destination of requester i, slice [i*AW +: AW].
- req_data  in  N_REQ*DW  result of requester i, slice [i*DW +: DW].
- wr_en  out  1  register file write enable.
- wr_addr  out  AW  register file write address.
- wr_data  out  DW  register file write data.
- wr_src  out  2  index of requester whose write is on the port.
- sb_set_valid  in  1  issue stage marks a destination pending.
- sb_set_addr  in  AW  destination to mark.
- sb_busy  out  32  pending-write mask, bit r = register r awaited.

## Operation
- Handshake: transfer when req_valid[i] && req_ready[i]. req_valid must not depend on req_ready; once raised, held with stable addr/data until transfer.
- req_ready is combinational from req_valid and arbitration state; at most one bit set; zero when no valid.
- Transfer in cycle t: wr_en=1, wr_addr/wr_data/wr_src = granted request in cycle t+1. No transfer: wr_en=0, other write outputs hold.
- Address 0: transfer completes normally but wr_en stays 0 in t+1 (register 0 never written).
- Scoreboard: sb_set_valid with sb_set_addr≠0 sets bit on next edge. Bit cleared on the edge that registers a transfer to that address. Same edge set and clear of same address: set wins. sb_busy[0] always 0. Setting an already-set bit: no change.
- Back-to-back: one transfer every cycle sustained; no bubble.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, wr_src=0, sb_busy=0, arbitration pointer=0; req_ready follows combinationally (priority from pointer 0).
- Latency: handshake to write port 1 cycle; set to sb_busy 1 cycle; transfer to sb_busy clear 1 cycle (same cycle wr_en asserts).
- Reset asserted mid-operation: in-flight write dropped (wr_en=0 immediately), all pending bits cleared; requesters must re-present after rst_n deasserts.

## Configuration
- REG_WB_RR_EN defined: round-robin; pointer moves to (granted+1) mod N_REQ after each transfer, search starts at pointer; no requester waits more than N_REQ-1 transfers.
- Not defined: fixed priority, lowest index wins; pointer logic absent.

## Structure
- Package reg_ctrl_pkg: AW, DW, N_REQ defaults, REG_COUNT=32, requester index type, ZERO_REG constant.
- Sub-module reg_wb_pick: combinational N_REQ picker (valid vector, start pointer -> one-hot grant + index); instantiated once, fixed-priority when pointer tied to 0.

## Test plan
- Reset: drive all valids high during rst_n=0 -> req_ready=001 combinationally, wr_en=0, sb_busy=0; after release first write is requester 0.
- Single write: req 1 valid, addr 5, data 0xDEADBEEF -> ready[1] same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_src=1.
- Contention, all three valid for 6 cycles: with REG_WB_RR_EN grant order 0,1,2,0,1,2; without it 0,0,0... while req 0 stays valid.
- Scoreboard: set addr 7 -> sb_busy[7]=1 next cycle; write to 7 -> bit clears in the cycle wr_en=1; same-edge set and write to 7 -> bit stays 1.
- Register 0: set addr 0 -> sb_busy unchanged; transfer to addr 0 -> handshake completes, wr_en stays 0.
- Reset mid-stream: assert rst_n low the cycle after a transfer to addr 9 with bit 9 set -> wr_en=0 and sb_busy=0 immediately.
